// File: rtl/sram_bist_ctrl_if.sv
// -----------------------------------------------------------------------------
// sram_bist_ctrl_if
// Control/status bundle between a host and the SRAM BIST controller.
//   start, abort        host -> BIST  test launch (level) / terminate
//   mode, pattern       host -> BIST  data-pattern selection, latched at start
//   stop_on_fail        host -> BIST  halt at first miscompare, latched at start
//   busy, done, pass    BIST -> host  run status; pass is valid with done
//   err_count           BIST -> host  saturating miscompare count
//   fail_addr/exp/act   BIST -> host  details of the first miscompare
// -----------------------------------------------------------------------------
interface sram_bist_ctrl_if #(
  parameter int WORD_SIZE = 8,
  parameter int ADDR_SIZE = 11
);
  logic                 start;
  logic                 abort;
  logic [1:0]           mode;
  logic [WORD_SIZE-1:0] pattern;
  logic                 stop_on_fail;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [7:0]           err_count;
  logic [ADDR_SIZE-1:0] fail_addr;
  logic [WORD_SIZE-1:0] fail_exp;
  logic [WORD_SIZE-1:0] fail_act;

  modport master (
    output start, abort, mode, pattern, stop_on_fail,
    input  busy, done, pass, err_count, fail_addr, fail_exp, fail_act
  );

  modport slave (
    input  start, abort, mode, pattern, stop_on_fail,
    output busy, done, pass, err_count, fail_addr, fail_exp, fail_act
  );
endinterface

// File: rtl/sram_bist_ctrl.sv
// -----------------------------------------------------------------------------
// sram_bist_ctrl
// Built-in self-test controller for an asynchronous SRAM with active-low
// CS_b/WE_b/OE_b and a shared bidirectional data bus. Writes a pattern to every
// address (column outer loop, row inner loop), then reads every address back in
// the same order and compares. Bus timing is set in clock cycles by parameters.
//   clk, rst_b   clock, asynchronous active-low reset
//   ctl          control/status bundle (slave side)
//   addr         SRAM address {row, col}
//   CS_b/WE_b/OE_b  SRAM strobes, registered so they never glitch
//   data_bus     driven only during write states, otherwise high impedance
// -----------------------------------------------------------------------------
module sram_bist_ctrl #(
  parameter int                   WORD_SIZE     = 8,
  parameter int                   ROW_ADDR_SIZE = 7,
  parameter int                   COL_ADDR_SIZE = 4,
  parameter logic [WORD_SIZE-1:0] INIT_PATTERN  = 8'h01,
  parameter int                   WR_SETUP_CYC  = 1,
  parameter int                   WE_LOW_CYC    = 6,
  parameter int                   WR_HOLD_CYC   = 1,
  parameter int                   RD_CYC        = 12
) (
  input  logic                                   clk,
  input  logic                                   rst_b,
  sram_bist_ctrl_if.slave                        ctl,
  output logic [ROW_ADDR_SIZE+COL_ADDR_SIZE-1:0] addr,
  output logic                                   CS_b,
  output logic                                   WE_b,
  output logic                                   OE_b,
  inout  wire  [WORD_SIZE-1:0]                   data_bus
);

  localparam int MAX_WR  = (WR_SETUP_CYC > WE_LOW_CYC) ? WR_SETUP_CYC : WE_LOW_CYC;
  localparam int MAX_WH  = (MAX_WR > WR_HOLD_CYC) ? MAX_WR : WR_HOLD_CYC;
  localparam int MAX_CYC = (MAX_WH > RD_CYC) ? MAX_WH : RD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_SETUP = 3'd1;
  localparam logic [2:0] S_WR_LOW   = 3'd2;
  localparam logic [2:0] S_WR_HOLD  = 3'd3;
  localparam logic [2:0] S_RD       = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic [ROW_ADDR_SIZE-1:0] row_q;
  logic [COL_ADDR_SIZE-1:0] col_q;
  logic [WORD_SIZE-1:0]     walk_q;
  logic [1:0]               mode_q;
  logic [WORD_SIZE-1:0]     pattern_q;
  logic                     stop_q;
  logic                     drive_q;
  logic                     busy_q, done_q, pass_q;
  logic [7:0]               err_q, err_d;
  logic [ROW_ADDR_SIZE+COL_ADDR_SIZE-1:0] fail_addr_q;
  logic [WORD_SIZE-1:0]     fail_exp_q, fail_act_q;

  logic [WORD_SIZE-1:0]     exp_data;
  logic                     cnt_last, last_addr, step, miscmp, launch;

  assign addr          = {row_q, col_q};
  assign data_bus      = drive_q ? exp_data : {WORD_SIZE{1'bz}};
  assign ctl.busy      = busy_q;
  assign ctl.done      = done_q;
  assign ctl.pass      = pass_q;
  assign ctl.err_count = err_q;
  assign ctl.fail_addr = fail_addr_q;
  assign ctl.fail_exp  = fail_exp_q;
  assign ctl.fail_act  = fail_act_q;

  assign last_addr = (&row_q) && (&col_q);
  assign step      = cnt_last && ((state_q == S_WR_HOLD) || (state_q == S_RD));
  assign miscmp    = cnt_last && (state_q == S_RD) && (data_bus != exp_data);
  assign launch    = ctl.start && !ctl.abort && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign err_d     = !miscmp ? err_q : ((err_q == 8'hFF) ? 8'hFF : err_q + 8'd1);

  // Expected word for the current address; the write and read phases both use
  // it, so they agree by construction. walk_q tracks INIT_PATTERN rotated by row.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    exp_data = pattern_q;
    case (mode_q)
      2'b00:   exp_data = walk_q;
      2'b10:   exp_data = (row_q[0] ^ col_q[0]) ? ~pattern_q : pattern_q;
      default: exp_data = pattern_q;
    endcase
  end

  // Idle/done states report their count as finished so cnt_q rests at zero.
  always_comb begin
    cnt_last = 1'b1;
    case (state_q)
      S_WR_SETUP: cnt_last = (cnt_q == CNT_W'(WR_SETUP_CYC - 1));
      S_WR_LOW:   cnt_last = (cnt_q == CNT_W'(WE_LOW_CYC - 1));
      S_WR_HOLD:  cnt_last = (cnt_q == CNT_W'(WR_HOLD_CYC - 1));
      S_RD:       cnt_last = (cnt_q == CNT_W'(RD_CYC - 1));
      default:    cnt_last = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (ctl.start) state_d = S_WR_SETUP;
      S_WR_SETUP: if (cnt_last) state_d = S_WR_LOW;
      S_WR_LOW:   if (cnt_last) state_d = S_WR_HOLD;
      S_WR_HOLD:  if (cnt_last) state_d = last_addr ? S_RD : S_WR_SETUP;
      S_RD:       if (cnt_last && (last_addr || (miscmp && stop_q))) state_d = S_DONE;
      S_DONE:     if (ctl.start) state_d = S_WR_SETUP;
      default:    state_d = S_IDLE;
    endcase
    if (ctl.abort) state_d = S_IDLE;
  end

  // Strobes are registered from the next state so they change cleanly on the
  // clock edge, and the async reset returns them high at once, cutting short
  // any write pulse in progress.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      walk_q      <= INIT_PATTERN;
      mode_q      <= 2'b00;
      pattern_q   <= '0;
      stop_q      <= 1'b0;
      drive_q     <= 1'b0;
      CS_b        <= 1'b1;
      WE_b        <= 1'b1;
      OE_b        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_act_q  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      cnt_q   <= (cnt_last || (state_d != state_q)) ? '0 : cnt_q + 1'b1;
      CS_b    <= (state_d == S_IDLE) || (state_d == S_DONE);
      WE_b    <= (state_d != S_WR_LOW);
      OE_b    <= (state_d != S_RD);
      drive_q <= (state_d == S_WR_SETUP) || (state_d == S_WR_LOW) || (state_d == S_WR_HOLD);

      if (launch) begin
        row_q       <= '0;
        col_q       <= '0;
        walk_q      <= INIT_PATTERN;
        mode_q      <= ctl.mode;
        pattern_q   <= ctl.pattern;
        stop_q      <= ctl.stop_on_fail;
        busy_q      <= 1'b1;
        done_q      <= 1'b0;
        pass_q      <= 1'b0;
        err_q       <= '0;
        fail_addr_q <= '0;
        fail_exp_q  <= '0;
        fail_act_q  <= '0;
      end else begin
        // Row is the inner loop; the walking seed restarts with every column.
        if (step) begin
          if (&row_q) begin
            row_q  <= '0;
            col_q  <= col_q + 1'b1;
            walk_q <= INIT_PATTERN;
          end else begin
            row_q  <= row_q + 1'b1;
            walk_q <= {walk_q[WORD_SIZE-2:0], walk_q[WORD_SIZE-1]};
          end
        end

        if (miscmp) begin
          err_q <= err_d;
          if (err_q == 8'd0) begin
            fail_addr_q <= {row_q, col_q};
            fail_exp_q  <= exp_data;
            fail_act_q  <= data_bus;
          end
        end

        if (ctl.abort) begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end else if ((state_d == S_DONE) && (state_q != S_DONE)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          pass_q <= (err_d == 8'd0);
        end
      end
    end
  end

endmodule
